// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: modulus, wrap/saturate, tc/wrap/ovf/match flags.
// Optional enable prescaler compiled in with `define COUNTER_PRESCALER_EN.
module param_updown_counter #(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      MAX_COUNT = {WIDTH{1'b1}},
   parameter int unsigned           PRESCALE  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic             sat,
   input  logic             clr_ovf,
   input  logic [WIDTH-1:0] cmp_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             match
);

   // Reject configurations outside the supported range at elaboration.
   if (WIDTH < 2 || WIDTH > 32 || MAX_COUNT == '0 || PRESCALE == 0) begin : g_param_check
      $error("param_updown_counter: illegal parameter combination");
   end

   logic             tick;
   logic             step;
   logic             boundary;
   logic [WIDTH-1:0] count_nxt;

`ifdef COUNTER_PRESCALER_EN
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_cnt;

   assign tick = en && (pre_cnt == PW'(PRESCALE - 1));

   // Prescaler phase: restarts on rst/load, frozen while en is low.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         pre_cnt <= '0;
      end else if (en) begin
         pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      end
   end
`else
   assign tick = en;
`endif

   assign tc       = up ? (count == MAX_COUNT) : (count == '0);
   assign step     = tick && !load;
   assign boundary = step && tc;

   // Next count: priority rst > load > step > hold, never exceeding MAX_COUNT.
   always_comb begin
      count_nxt = count;
      if (rst) begin
         count_nxt = '0;
      end else if (load) begin
         count_nxt = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
      end else if (step) begin
         if (up) begin
            if (count == MAX_COUNT) count_nxt = sat ? MAX_COUNT : '0;
            else                    count_nxt = count + WIDTH'(1);
         end else begin
            if (count == '0)        count_nxt = sat ? '0 : MAX_COUNT;
            else                    count_nxt = count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= boundary;
         if (boundary)     ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end
      // count_nxt is already zero under rst, so match follows cmp_val==0 there.
      match <= (count_nxt == cmp_val);
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised + directed bench for param_updown_counter against a behavioural model.
// Two instances share stimulus: full-range (MAX=255) and modulo-10 (MAX=9).
module tb_param_updown_counter;

   localparam int PS = 4;

   logic       clk = 1'b0;
   logic       rst, en, load, up, sat, clr_ovf;
   logic [7:0] load_val, cmp_val;
   logic [7:0] count_a, count_b;
   logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b, match_a, match_b;

   int n_checks = 0;
   int n_errors = 0;

   int m_cnt   [2];
   bit m_wrap  [2];
   bit m_ovf   [2];
   bit m_match [2];
   int m_phase;
   int maxv    [2] = '{255, 9};

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(8)) u_a (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
      .up(up), .sat(sat), .clr_ovf(clr_ovf), .cmp_val(cmp_val),
      .count(count_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a), .match(match_a));

   param_updown_counter #(.WIDTH(8), .MAX_COUNT(8'd9)) u_b (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
      .up(up), .sat(sat), .clr_ovf(clr_ovf), .cmp_val(cmp_val),
      .count(count_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b), .match(match_b));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Arithmetic on the closed range 0..mx: modular when wrapping, clamped when saturating.
   function automatic int model_next(input int c, input int mx, input bit u, input bit s);
      int m = mx + 1;
      if (s) return u ? ((c + 1 > mx) ? mx : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
      return u ? (c + 1) % m : (c + m - 1) % m;
   endfunction

   task automatic cycle(input bit r, input bit e, input bit l, input int lv,
                        input bit u, input bit s, input bit c, input int cv);
      bit tick;
      bit tc_m, bnd;
      int lvv;
      rst = r; en = e; load = l; load_val = 8'(lv); up = u; sat = s;
      clr_ovf = c; cmp_val = 8'(cv);
      lvv = int'(load_val);
      #1;
      check("tc_a", int'(tc_a), int'(u ? m_cnt[0] == maxv[0] : m_cnt[0] == 0));
      check("tc_b", int'(tc_b), int'(u ? m_cnt[1] == maxv[1] : m_cnt[1] == 0));
`ifdef COUNTER_PRESCALER_EN
      tick = e && (m_phase == PS - 1);
`else
      tick = e;
`endif
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
         end else if (l) begin
            m_cnt[i]  = (lvv > maxv[i]) ? maxv[i] : lvv;
            m_wrap[i] = 0;
            if (c) m_ovf[i] = 0;
         end else begin
            tc_m = u ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0);
            bnd  = tick && tc_m;
            if (tick) m_cnt[i] = model_next(m_cnt[i], maxv[i], u, s);
            m_wrap[i] = bnd;
            if (bnd) m_ovf[i] = 1;
            else if (c) m_ovf[i] = 0;
         end
         m_match[i] = (m_cnt[i] == int'(cmp_val));
      end
      if (r || l) m_phase = 0;
      else if (e) m_phase = (m_phase + 1) % PS;
      #1;
      check("count_a", int'(count_a), m_cnt[0]);
      check("count_b", int'(count_b), m_cnt[1]);
      check("wrap_a",  int'(wrap_a),  int'(m_wrap[0]));
      check("wrap_b",  int'(wrap_b),  int'(m_wrap[1]));
      check("ovf_a",   int'(ovf_a),   int'(m_ovf[0]));
      check("ovf_b",   int'(ovf_b),   int'(m_ovf[1]));
      check("match_a", int'(match_a), int'(m_match[0]));
      check("match_b", int'(match_b), int'(m_match[1]));
   endtask

   initial begin
      int exp12;
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1;
      sat = 1'b0; clr_ovf = 1'b0; cmp_val = '0;
      m_cnt = '{0, 0}; m_wrap = '{0, 0}; m_ovf = '{0, 0}; m_match = '{0, 0};
      m_phase = 0;

      // Reset and up-count from zero.
      repeat (2) cycle(1, 0, 0, 0, 1, 0, 0, 0);
      check("rst_count_a", int'(count_a), 0);
      check("rst_match_a", int'(match_a), 1);
      repeat (12) cycle(0, 1, 0, 0, 1, 0, 0, 200);
`ifdef COUNTER_PRESCALER_EN
      exp12 = 3;
`else
      exp12 = 12;
`endif
      check("upcount12_a", int'(count_a), exp12);

      // Modulo wrap at 9, then clear the sticky flag.
      cycle(0, 0, 1, 8, 1, 0, 0, 200);
      repeat (3 * PS) cycle(0, 1, 0, 0, 1, 0, 0, 200);
      cycle(0, 0, 0, 0, 1, 0, 1, 200);
      check("ovf_cleared_b", int'(ovf_b), 0);

      // Saturating down-count, then clamped load.
      cycle(0, 0, 1, 1, 0, 1, 0, 200);
      repeat (3 * PS) cycle(0, 1, 0, 0, 0, 1, 0, 200);
      check("sat_hold_b", int'(count_b), 0);
      cycle(0, 0, 1, 12, 0, 1, 0, 200);
      check("clamp_b", int'(count_b), 9);
      check("noclamp_a", int'(count_a), 12);

      // Load beats step; boundary event beats clr_ovf.
      cycle(0, 0, 1, 5, 1, 0, 0, 200);
      cycle(0, 1, 1, 8'hAA, 1, 0, 0, 200);
      check("load_wins_a", int'(count_a), 8'hAA);
      check("load_clamp_b", int'(count_b), 9);
      repeat (PS) cycle(0, 1, 0, 0, 1, 0, 1, 200);

      // Compare match while counting up, then reset mid-count.
      cycle(1, 0, 0, 0, 1, 0, 0, 3);
      repeat (7 * PS) cycle(0, 1, 0, 0, 1, 0, 0, 3);
      cycle(1, 1, 0, 0, 1, 0, 0, 3);
      check("midrst_count_a", int'(count_a), 0);

      // Enable gap mid-period: prescaler phase must be held.
      repeat (2) cycle(0, 1, 0, 0, 1, 0, 0, 3);
      repeat (5) cycle(0, 0, 0, 0, 1, 0, 0, 3);
      repeat (2 * PS + 1) cycle(0, 1, 0, 0, 1, 0, 0, 3);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
               int'($urandom % 256), 1'($urandom), 1'($urandom),
               ($urandom % 8) == 0, int'($urandom % 13));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's 8-bit load/count counter.
- Adds configurable width and modulus, up/down direction, wrap or saturate mode, terminal-count and wrap flags, a sticky overflow flag, a compare-match output, and an optional enable prescaler.
- Sits behind the tt_um_* top-level pin mapping as the general-purpose counter primitive for timers and sequencers.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_COUNT, 2**WIDTH-1, modulus top value; count range is 0..MAX_COUNT. Must be >= 1 and <= 2**WIDTH-1.
- PRESCALE, 4, enable divide ratio (>= 1); used only when COUNTER_PRESCALER_EN is defined.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 1 = saturate at bounds, 0 = wrap.
- clr_ovf  in  1  clears the sticky ovf flag.
- cmp_val  in  WIDTH  compare value.
- count  out  WIDTH  registered counter value.
- tc  out  1  combinational terminal count: (up && count==MAX_COUNT) || (!up && count==0).
- wrap  out  1  registered one-cycle pulse: a boundary event occurred on the previous edge.
- ovf  out  1  sticky, registered boundary-event flag.
- match  out  1  registered: count == cmp_val, evaluated on the new count value.

Behaviour:
- Reset values: count=0, wrap=0, ovf=0, match=(cmp_val==0) on the first cycle after reset; prescaler counter=0.
- Per-edge priority: rst > load > count step > hold.
- Load: count <= min(load_val, MAX_COUNT), clamped. Load ignores en and does not produce wrap/ovf.
- Step condition: en=1 (and the prescaler tick, if compiled in) and load=0.
- Up, count<MAX_COUNT: count+1.
- Up, count==MAX_COUNT: sat=0 → 0; sat=1 → hold MAX_COUNT.
- Down, count>0: count-1.
- Down, count==0: sat=0 → MAX_COUNT; sat=1 → hold 0.
- Boundary event: a step taken while tc=1, in either mode (a saturating hold also counts). Effect on the same edge: wrap<=1, ovf<=1. wrap returns to 0 on the next edge unless another boundary event occurs; consecutive events keep wrap high.
- ovf clear: clr_ovf=1 clears ovf unless a boundary event happens on the same edge; set wins.
- Direction or mode change: takes effect on the next edge; no internal pipeline state.
- Arithmetic: modulo MAX_COUNT+1, never 2**WIDTH, unless MAX_COUNT=2**WIDTH-1. No intermediate value ever exceeds MAX_COUNT.
- Reset mid-operation: all registers return to reset values on that edge; pending load or step is discarded.
- Latency: count, wrap, ovf and match all update 1 cycle after the qualifying inputs. tc is combinational from count and up.

Optional Feature:
- Macro: COUNTER_PRESCALER_EN.
- Defined:
  - An internal prescaler counts 0..PRESCALE-1 on every edge with en=1, and generates a tick when it is at PRESCALE-1 and en=1.
  - The main counter steps only on a tick.
  - load resets the prescaler to 0. rst resets it to 0.
  - en=0 freezes the prescaler.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; the step condition is en && !load.

Test Plan:
- Reset and up-count (WIDTH=8, MAX_COUNT=255): rst=1 for 2 cycles, then en=1, up=1, sat=0 for 8 cycles → count goes 1..8, wrap=0, ovf=0.
- Modulo wrap (MAX_COUNT=9): load 8, then up-count 3 cycles → count 9 (tc=1), 0 (wrap=1, ovf=1), 1 (wrap=0, ovf=1). Then clr_ovf pulse → ovf=0.
- Saturate and down (MAX_COUNT=9): sat=1, up=0, load 1, step 3 cycles → count 0, 0, 0; wrap=1 on the 2nd and 3rd. Then load 12 → count=9 (clamped).
- Simultaneous events: load=1 with en=1 at count=5, load_val=0xAA (MAX=255) → count=0xAA, no step. Boundary event coincident with clr_ovf → ovf stays 1.
- Compare: cmp_val=0x03, up-count from 0 → match=1 exactly in the cycle count==3, 0 otherwise. Assert rst while count=7 → count=0, ovf=0, wrap=0 on the next edge.
- Prescaler (COUNTER_PRESCALER_EN, PRESCALE=4): en=1 for 12 cycles from reset → count steps once every 4 edges, reaching 3. en low for 5 cycles mid-period → no step; phase resumes where it stopped.
